draw_sprite: RTL



---
 rtl/draw_sprite_if.sv | 14 +
 rtl/draw_sprite.sv | 135 +++++++++++++
 2 files changed

// File: rtl/draw_sprite_if.sv
// vga_if: pixel-clock VGA timing bundle (counters, syncs, blanks, 12-bit colour)
// shared by the stages of the video pipeline.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// draw_sprite: overlays an IMG_W x IMG_H ROM image, optionally upscaled, at a per-frame position.
// Define DRAW_SPRITE_KEY_EN to make ROM pixels equal to KEY_COLOR transparent.
module draw_sprite #(
  parameter int          IMG_W       = 156,
  parameter int          IMG_H       = 200,
  parameter int          ADDR_W      = 15,
  parameter int          SCALE_LOG2  = 0,
  parameter int          ROM_LATENCY = 1,
  parameter int          X_INIT      = 50,
  parameter int          Y_INIT      = 50,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  input  logic              en,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  vga_if.in                 in,
  vga_if.out                out
);

`ifdef DRAW_SPRITE_KEY_EN
  localparam logic KEY_ON = 1'b1;
`else
  localparam logic KEY_ON = 1'b0;
`endif
  localparam logic [12:0] SPR_W = 13'(IMG_W << SCALE_LOG2);
  localparam logic [12:0] SPR_H = 13'(IMG_H << SCALE_LOG2);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vid_t;

  typedef struct packed {
    vid_t vid;
    logic hit;
  } pipe_t;

  logic [10:0]       x0_r;
  logic [10:0]       y0_r;
  logic              en_r;
  logic [11:0]       dx_s;
  logic [11:0]       dy_s;
  logic [10:0]       col_s;
  logic [10:0]       row_s;
  logic              hit_s;
  logic [ADDR_W-1:0] addr_s;
  pipe_t             stage0_s;
  pipe_t             last_s;
  pipe_t             dly_r [ROM_LATENCY+1];
  logic [11:0]       rgb_s;
  vid_t              out_r;

  // Frame-start latch of position and enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_r <= 11'(X_INIT);
      y0_r <= 11'(Y_INIT);
      en_r <= 1'b1;
    end else if ((in.hcount == 11'd0) && (in.vcount == 11'd0)) begin
      x0_r <= xpos;
      y0_r <= ypos;
      en_r <= en;
    end
  end

  // Stage 0 hit test and ROM address; a negative offset shows up in bit 11, so no wrap
  always_comb begin
    dx_s   = {1'b0, in.hcount} - {1'b0, x0_r};
    dy_s   = {1'b0, in.vcount} - {1'b0, y0_r};
    col_s  = dx_s[10:0] >> SCALE_LOG2;
    row_s  = dy_s[10:0] >> SCALE_LOG2;
    addr_s = ADDR_W'(row_s) * ADDR_W'(IMG_W) + ADDR_W'(col_s);
    hit_s  = en_r && !dx_s[11] && !dy_s[11] &&
             ({2'b00, dx_s[10:0]} < SPR_W) && ({2'b00, dy_s[10:0]} < SPR_H) &&
             !in.hblnk && !in.vblnk;
    stage0_s.vid.hcount = in.hcount;
    stage0_s.vid.vcount = in.vcount;
    stage0_s.vid.hsync  = in.hsync;
    stage0_s.vid.hblnk  = in.hblnk;
    stage0_s.vid.vsync  = in.vsync;
    stage0_s.vid.vblnk  = in.vblnk;
    stage0_s.vid.rgb    = in.rgb;
    stage0_s.hit        = hit_s;
  end

  // ROM address register and timing delay line matching the ROM latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) dly_r[i] <= '0;
    end else begin
      pixel_addr <= hit_s ? addr_s : '0;
      dly_r[0]   <= stage0_s;
      for (int i = 1; i <= ROM_LATENCY; i++) dly_r[i] <= dly_r[i-1];
    end
  end

  // Colour select: ROM pixel on a hit unless it is the key colour
  always_comb begin
    last_s = dly_r[ROM_LATENCY];
    if (last_s.hit && !(KEY_ON && (rgb_pixel == KEY_COLOR))) begin
      rgb_s = rgb_pixel;
    end else begin
      rgb_s = last_s.vid.rgb;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= '0;
    end else begin
      out_r     <= last_s.vid;
      out_r.rgb <= rgb_s;
    end
  end

  assign out.hcount = out_r.hcount;
  assign out.vcount = out_r.vcount;
  assign out.hsync  = out_r.hsync;
  assign out.hblnk  = out_r.hblnk;
  assign out.vsync  = out_r.vsync;
  assign out.vblnk  = out_r.vblnk;
  assign out.rgb    = out_r.rgb;

endmodule
